// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_UDIV = 2'b01,
    OP_SDIV = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  // Widest supported N; the top slices its own width out of this.
  localparam int unsigned MAX_N = 128;
  localparam logic [MAX_N-1:0] DBZ_RESULT = '1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: shift-add for MUL, restoring
// subtract-compare-shift for UDIV/SDIV.
module muldiv_step #(
  parameter int N = 64
) (
  input  logic         is_div,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] x_nxt,
  output logic [N-1:0] y_nxt,
  output logic [N-1:0] z_nxt
);

  logic [N:0] rem_sh;
  logic [N:0] diff;
  logic       ge;

  always_comb begin
    // x: accumulator / partial remainder, y: multiplier / dividend->quotient,
    // z: multiplicand / divisor
    rem_sh = {x, y[N-1]};
    diff   = rem_sh - {1'b0, z};
    ge     = ~diff[N];
    x_nxt  = x;
    y_nxt  = y;
    z_nxt  = z;
    if (is_div) begin
      x_nxt = ge ? diff[N-1:0] : rem_sh[N-1:0];
      y_nxt = {y[N-2:0], ge};
      z_nxt = z;
    end else begin
      x_nxt = y[0] ? (x + z) : x;
      y_nxt = y >> 1;
      z_nxt = z << 1;
    end
  end

endmodule

// File: rtl/iterative_muldiv.sv
// Multi-cycle N-bit multiply/divide unit with start/busy/done handshake.
//   state  | meaning
//   S_IDLE | waiting; start accepted here
//   S_RUN  | iterating, one bit per cycle for N cycles
//   S_DONE | done pulse; result/zero/dbz valid
module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         dbz
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   x_q, y_q, z_q;
  logic [N-1:0]   x_nxt, y_nxt, z_nxt;
  logic           div_q, neg_q;
  logic [N-1:0]   result_q;
  logic           zero_q, dbz_q;

  logic           accept, op_div, op_sdiv, b_zero, last;
  logic [N-1:0]   a_mag, b_mag, res_fin;

  assign op_div  = (op == OP_UDIV) || (op == OP_SDIV);
  assign op_sdiv = (op == OP_SDIV);
  assign b_zero  = (b == '0);
  assign accept  = (state_q == S_IDLE) && start;
  assign last    = (state_q == S_RUN) && (cnt_q == CW'(N - 1));
  assign a_mag   = (op_sdiv && a[N-1]) ? -a : a;
  assign b_mag   = (op_sdiv && b[N-1]) ? -b : b;
  assign res_fin = div_q ? (neg_q ? -y_nxt : y_nxt) : x_nxt;

  muldiv_step #(.N(N)) u_step (
    .is_div (div_q),
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .x_nxt  (x_nxt),
    .y_nxt  (y_nxt),
    .z_nxt  (z_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = (op_div && b_zero) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      dbz_q    <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      dbz_q <= 1'b0;
      div_q <= op_div;
      neg_q <= op_sdiv && (a[N-1] ^ b[N-1]);
      x_q   <= '0;
      if (op_div) begin
        y_q <= a_mag;
        z_q <= b_mag;
      end else begin
        y_q <= b;
        z_q <= a;
      end
      // Divide-by-zero skips RUN and publishes its result straight away
      if (op_div && b_zero) begin
        result_q <= DBZ_RESULT[N-1:0];
        zero_q   <= 1'b0;
        dbz_q    <= 1'b1;
      end
    end else if (state_q == S_RUN) begin
      cnt_q <= last ? '0 : cnt_q + CW'(1);
      x_q   <= x_nxt;
      y_q   <= y_nxt;
      z_q   <= z_nxt;
      if (last) begin
        result_q <= res_fin;
        zero_q   <= (res_fin == '0);
      end
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign dbz    = dbz_q;

endmodule
